// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one combinational ALU between two
// valid/ready requesters, with registered operands and a tagged response.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   reqN_valid/ready         per-requester handshake (N = 0, 1)
//   reqN_opcode/a/b/cin      per-requester operation payload
//   alu_opcode/a/b/cin       registered operands toward the ALU
//   alu_y/cout/overflow/
//   alu_negative/zero        combinational ALU result
//   resp_valid/ready         response handshake
//   resp_id, resp_y,
//   resp_flags               owner, result, {cout, overflow, negative, zero}
//   busy                     FSM away from IDLE
//   op_count                 saturating count of handed-off responses
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int OPW   = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  input  logic             alu_negative,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_y,
  output logic [3:0]       resp_flags,
  output logic             busy,
  output logic [CNTW-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  logic   last_grant;
  logic   cur_id;
  logic   idle;

  // Readies are combinational so a grant costs no extra cycle; they are
  // held low while reset is asserted.
  assign idle = (state == IDLE) && !rst;

  // On contention the requester that did not win last time is served.
  assign req0_ready = idle && req0_valid
                   && (!req1_valid || last_grant);
  assign req1_ready = idle && req1_valid
                   && (!req0_valid || !last_grant);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_y     <= '0;
      resp_flags <= '0;
      op_count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0_ready) begin
            alu_opcode <= req0_opcode;
            alu_a      <= req0_a;
            alu_b      <= req0_b;
            alu_cin    <= req0_cin;
            cur_id     <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end else if (req1_ready) begin
            alu_opcode <= req1_opcode;
            alu_a      <= req1_a;
            alu_b      <= req1_b;
            alu_cin    <= req1_cin;
            cur_id     <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_y     <= alu_y;
          resp_flags <= {alu_cout, alu_overflow,
                         alu_negative, alu_zero};
          resp_id    <= cur_id;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (op_count != {CNTW{1'b1}})
              op_count <= op_count + CNTW'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: stimulus, ALU stand-in and scoreboard for alu_arbiter.
// Table vectors, directed corner sequences and random traffic.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_opcode, req1_opcode;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_cin, req1_cin;
  logic [3:0] alu_opcode, alu_a, alu_b, alu_y;
  logic       alu_cin, alu_cout, alu_overflow;
  logic       alu_negative, alu_zero;
  logic       resp_valid, resp_ready, resp_id;
  logic [3:0] resp_y, resp_flags;
  logic       busy;
  logic [7:0] op_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(4), .OPW(4), .CNTW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_opcode(req0_opcode), .req0_a(req0_a),
    .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_opcode(req1_opcode), .req1_a(req1_a),
    .req1_b(req1_b), .req1_cin(req1_cin),
    .alu_opcode(alu_opcode), .alu_a(alu_a),
    .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_y(resp_y),
    .resp_flags(resp_flags), .busy(busy),
    .op_count(op_count)
  );

  // 4-bit ALU: 0 add, 1 sub (a + ~b + cin), 2 and, 3 or, 4 xor, else a.
  // Returns {y, cout, overflow, negative, zero}.
  function automatic logic [7:0] alu_fn(input logic [3:0] op,
                                        input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic cin);
    int s;
    logic [3:0] y, nb;
    logic co, ov;
    nb = ~b;
    co = 1'b0;
    ov = 1'b0;
    case (op)
      4'd0: begin
        s = int'(a) + int'(b) + int'(cin);
        y = s[3:0]; co = s[4];
        ov = (a[3] == b[3]) && (y[3] != a[3]);
      end
      4'd1: begin
        s = int'(a) + int'(nb) + int'(cin);
        y = s[3:0]; co = s[4];
        ov = (a[3] != b[3]) && (y[3] != a[3]);
      end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      default: y = a;
    endcase
    return {y, co, ov, y[3], (y == 4'd0)};
  endfunction

  always_comb
    {alu_y, alu_cout, alu_overflow, alu_negative, alu_zero} =
      alu_fn(alu_opcode, alu_a, alu_b, alu_cin);

  typedef struct {
    logic       id;
    logic [3:0] y;
    logic [3:0] f;
  } rsp_t;

  rsp_t       exp_q[$];
  int         lat;
  logic       m_last;
  int         m_count;
  logic [3:0] m_op, m_a, m_b;
  logic       m_cin;
  int         g_seen;
  int         ncyc;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    lat = 0;
    m_last = 1'b1;
    m_count = 0;
    m_op = '0; m_a = '0; m_b = '0; m_cin = 1'b0;
  endtask

  // One clock: check at the falling edge, advance the model, then
  // return 1 time unit after the rising edge for new stimulus.
  task automatic cycle();
    int eg;
    logic [7:0] r;
    bit vis;
    @(negedge clk);
    eg = -1;
    if (!rst && exp_q.size() == 0) begin
      if (req0_valid && req1_valid) eg = m_last ? 0 : 1;
      else if (req0_valid) eg = 0;
      else if (req1_valid) eg = 1;
    end
    vis = (exp_q.size() != 0) && (lat == 0);
    chk("req0_ready", 32'(req0_ready), 32'(eg == 0));
    chk("req1_ready", 32'(req1_ready), 32'(eg == 1));
    chk("busy", 32'(busy), 32'(exp_q.size() != 0));
    chk("resp_valid", 32'(resp_valid), 32'(vis));
    chk("op_count", 32'(op_count), 32'(m_count));
    chk("alu_operands", {19'd0, alu_opcode, alu_a, alu_b, alu_cin},
        {19'd0, m_op, m_a, m_b, m_cin});
    if (vis) begin
      chk("resp_id", 32'(resp_id), 32'(exp_q[0].id));
      chk("resp_y", 32'(resp_y), 32'(exp_q[0].y));
      chk("resp_flags", 32'(resp_flags), 32'(exp_q[0].f));
    end
    g_seen = eg;
    if (!rst) begin
      if (exp_q.size() != 0) begin
        if (lat == 0) begin
          if (resp_ready) begin
            void'(exp_q.pop_front());
            if (m_count < 255) m_count++;
          end
        end else begin
          lat--;
        end
      end
      if (eg >= 0) begin
        if (eg == 0) begin
          m_op = req0_opcode; m_a = req0_a;
          m_b = req0_b; m_cin = req0_cin;
        end else begin
          m_op = req1_opcode; m_a = req1_a;
          m_b = req1_b; m_cin = req1_cin;
        end
        r = alu_fn(m_op, m_a, m_b, m_cin);
        exp_q.push_back('{id: eg[0], y: r[7:4], f: r[3:0]});
        m_last = eg[0];
        lat = 1;
      end
    end
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin
      cycle();
      n++;
    end
    if (!resp_valid) begin
      checks++;
      failures++;
      $display("FAIL wait_resp: resp_valid=0 required 1 after 20 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 30) begin
      cycle();
      n++;
    end
  endtask

  task automatic set0(input logic [3:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic cin);
    req0_opcode = op; req0_a = a; req0_b = b; req0_cin = cin;
  endtask

  task automatic set1(input logic [3:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic cin);
    req1_opcode = op; req1_a = a; req1_b = b; req1_cin = cin;
  endtask

  typedef struct {
    logic       id;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] y;
    logic [3:0] f;
  } vec_t;

  vec_t tbl[7];
  int   gq[$];
  int   gc[$];
  int   cnt0;

  initial begin
    tbl[0] = '{0, 4'h0, 4'h1, 4'h1, 1'b0, 4'h2, 4'h0};
    tbl[1] = '{0, 4'h0, 4'hF, 4'h1, 1'b0, 4'h0, 4'h9};
    tbl[2] = '{1, 4'h0, 4'h7, 4'h1, 1'b0, 4'h8, 4'h6};
    tbl[3] = '{0, 4'h0, 4'h3, 4'h1, 1'b0, 4'h4, 4'h0};
    tbl[4] = '{1, 4'h1, 4'h5, 4'h3, 1'b1, 4'h2, 4'h8};
    tbl[5] = '{0, 4'h2, 4'hC, 4'hA, 1'b0, 4'h8, 4'h2};
    tbl[6] = '{1, 4'h4, 4'h5, 4'h5, 1'b0, 4'h0, 4'h1};

    ncyc = 0;
    g_seen = -1;
    req0_valid = 0; req1_valid = 0;
    set0(0, 0, 0, 0); set1(0, 0, 0, 0);
    resp_ready = 1;
    rst = 1;
    model_reset();
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_op_count", 32'(op_count), 0);
    repeat (2) cycle();
    rst = 0;

    // Contention straight out of reset: requester 0 first.
    req0_valid = 1; set0(0, 4'h3, 4'h1, 0);
    req1_valid = 1; set1(0, 4'h7, 4'h1, 0);
    cycle();
    chk("cont_grant0", 32'(g_seen), 0);
    req0_valid = 0;
    wait_resp();
    chk("cont_id0", 32'(resp_id), 0);
    chk("cont_y0", 32'(resp_y), 32'h4);
    cycle();
    cycle();
    chk("cont_grant1", 32'(g_seen), 1);
    req1_valid = 0;
    wait_resp();
    chk("cont_id1", 32'(resp_id), 1);
    chk("cont_y1", 32'(resp_y), 32'h8);
    chk("cont_f1", 32'(resp_flags), 32'h6);
    cycle();
    drain();

    // Table vectors, one requester at a time, fixed latency.
    foreach (tbl[i]) begin
      cnt0 = int'(op_count);
      if (tbl[i].id) begin
        req1_valid = 1; set1(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin);
      end else begin
        req0_valid = 1; set0(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin);
      end
      cycle();
      chk("tbl_grant", 32'(g_seen), 32'(tbl[i].id));
      req0_valid = 0; req1_valid = 0;
      chk("tbl_lat1", 32'(resp_valid), 0);
      cycle();
      chk("tbl_lat2", 32'(resp_valid), 1);
      chk("tbl_id", 32'(resp_id), 32'(tbl[i].id));
      chk("tbl_y", 32'(resp_y), 32'(tbl[i].y));
      chk("tbl_flags", 32'(resp_flags), 32'(tbl[i].f));
      cycle();
      chk("tbl_count", 32'(op_count), 32'(cnt0 + 1));
      chk("tbl_hold_a", 32'(alu_a), 32'(tbl[i].a));
    end

    // Backpressure with requester 1 waiting.
    resp_ready = 0;
    req0_valid = 1; set0(0, 4'h2, 4'h3, 0);
    cycle();
    req0_valid = 0;
    req1_valid = 1; set1(0, 4'h1, 4'h1, 1);
    wait_resp();
    repeat (5) begin
      cycle();
      chk("bp_valid", 32'(resp_valid), 1);
      chk("bp_y", 32'(resp_y), 32'h5);
      chk("bp_flags", 32'(resp_flags), 32'h0);
      chk("bp_ready1", 32'(req1_ready), 0);
    end
    resp_ready = 1;
    cycle();
    cycle();
    chk("bp_grant", 32'(g_seen), 1);
    req1_valid = 0;
    wait_resp();
    chk("bp_y1", 32'(resp_y), 32'h3);
    cycle();
    drain();

    // Asynchronous reset while in EXEC.
    req0_valid = 1; set0(0, 4'h9, 4'h2, 0);
    cycle();
    req0_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_resp_valid", 32'(resp_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_op_count", 32'(op_count), 0);
    chk("arst_alu_a", 32'(alu_a), 0);
    model_reset();
    repeat (2) cycle();
    rst = 0;
    repeat (4) cycle();
    chk("arst_no_resp", 32'(resp_valid), 0);
    req1_valid = 1; set1(0, 4'h6, 4'h1, 0);
    cycle();
    chk("arst_grant", 32'(g_seen), 1);
    req1_valid = 0;
    wait_resp();
    chk("arst_y", 32'(resp_y), 32'h7);
    cycle();
    drain();

    // Fairness: both valid continuously.
    req0_valid = 1; set0(0, 4'h1, 4'h2, 0);
    req1_valid = 1; set1(3, 4'h4, 4'h2, 0);
    for (int n = 0; n < 40 && gq.size() < 6; n++) begin
      cycle();
      if (g_seen >= 0) begin
        gq.push_back(g_seen);
        gc.push_back(ncyc);
      end
    end
    req0_valid = 0; req1_valid = 0;
    chk("fair_count", 32'(gq.size()), 6);
    for (int i = 0; i < gq.size(); i++) begin
      chk("fair_order", 32'(gq[i]), 32'(i % 2));
      if (i > 0) chk("fair_spacing", 32'(gc[i] - gc[i-1]), 3);
    end
    drain();

    // Random traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      set0(4'($urandom_range(0, 5)), 4'($urandom), 4'($urandom),
           1'($urandom));
      set1(4'($urandom_range(0, 5)), 4'($urandom), 4'($urandom),
           1'($urandom));
      resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 1;
    drain();

    // Counter saturation.
    req0_valid = 1; set0(0, 4'h1, 4'h1, 0);
    repeat (270 * 3) cycle();
    req0_valid = 0;
    drain();
    chk("sat_count", 32'(op_count), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
